// File: rtl/seq_detect_arbiter_if.sv
// seq_detect_arbiter_if: request/grant/result bundle between the requesting
// channels (master) and the shared-detector arbiter (slave).
interface seq_detect_arbiter_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 5
);
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   bit_in;
    logic [NCH-1:0]   gnt;
    logic             busy;
    logic             done;
    logic [2:0]       done_ch;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output req, bit_in,
        input  gnt, busy, done, done_ch, match_cnt
    );

    modport slave (
        input  req, bit_in,
        output gnt, busy, done, done_ch, match_cnt
    );
endinterface

// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: time-shares one external bit-serial Moore detector among
// NCH serial channels. One frame per grant: clear the detector, stream
// FRAME_LEN bits from the owner, count det_y highs (saturating), report.
// Optional: define SEQ_ARB_FIXED_PRI_EN for lowest-index-wins arbitration
// (no round-robin pointer); default build is round-robin.

// Per-channel data steering: a lane forwards its serial bit only while it
// holds the grant and the frame is streaming.
module seq_detect_arbiter_lane (
    input  logic en,
    input  logic gnt,
    input  logic bit_in,
    output logic x
);
    assign x = en & gnt & bit_in;
endmodule

module seq_detect_arbiter #(
    parameter int NCH       = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detect_arbiter_if.slave  bus,
    output logic                 det_clr,
    output logic                 det_x,
    input  logic                 det_y
);
    localparam int CH_W  = 3;
    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [NCH-1:0]   gnt_q;
    logic [CH_W-1:0]  owner;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_q;
    logic [CH_W-1:0]  done_ch_q;
    logic [CNT_W-1:0] match_q;
    logic             pick_vld;
    logic [CH_W-1:0]  pick_ch;
    logic [NCH-1:0]   lane_x;
    logic             stream_en;

`ifdef SEQ_ARB_FIXED_PRI_EN
    // Fixed priority: lowest-index requester wins (descending scan, last hit kept).
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (bus.req[c]) begin
                pick_vld = 1'b1;
                pick_ch  = CH_W'(c);
            end
        end
    end
`else
    logic [CH_W-1:0] ptr;

    // Round-robin: first requester at or above ptr with wrap. Offsets are scanned
    // high to low so the smallest offset overrides; channel selection compares
    // against ptr so every bit select stays constant.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.req[c] && (ptr == CH_W'((c + NCH - off) % NCH))) begin
                    pick_vld = 1'b1;
                    pick_ch  = CH_W'(c);
                end
            end
        end
    end
`endif

    // Saturating match count; det_y only advances it when not already full.
    assign cnt_nxt = (det_y && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;

    // Detector stays cleared through reset and during the CLR slot.
    assign det_clr   = rst | (state == S_CLR);
    assign stream_en = (state == S_STREAM) & ~rst;

    // Lane array: only the granted lane can drive the detector input.
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        seq_detect_arbiter_lane u_lane (
            .en     (stream_en),
            .gnt    (gnt_q[g]),
            .bit_in (bus.bit_in[g]),
            .x      (lane_x[g])
        );
    end

    assign det_x         = |lane_x;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.done_ch   = done_ch_q;
    assign bus.match_cnt = match_q;

    // Frame FSM: arbitrate in IDLE, then CLR -> STREAM x FRAME_LEN -> DRAIN -> DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt_q     <= '0;
            owner     <= '0;
            idx       <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
            match_q   <= '0;
`ifndef SEQ_ARB_FIXED_PRI_EN
            ptr       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt_q <= {{(NCH-1){1'b0}}, 1'b1} << pick_ch;
                        owner <= pick_ch;
                        state <= S_CLR;
`ifndef SEQ_ARB_FIXED_PRI_EN
                        ptr   <= (pick_ch == CH_W'(NCH - 1)) ? '0 : pick_ch + 1'b1;
`endif
                    end
                end
                S_CLR: begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    // det_y lags det_x by one cycle, so the first stream cycle is skipped.
                    if (idx != '0) cnt <= cnt_nxt;
                    if (idx == IDX_W'(FRAME_LEN - 1)) state <= S_DRAIN;
                    else                              idx   <= idx + 1'b1;
                end
                S_DRAIN: begin
                    // Last sample is the detector's answer for the final streamed bit.
                    cnt       <= cnt_nxt;
                    match_q   <= cnt_nxt;
                    done_ch_q <= owner;
                    done_q    <= 1'b1;
                    gnt_q     <= '0;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb_seq_detect_arbiter: scenario tasks drive frames cycle by cycle and check
// grant/stream timing inline; expected frame results go to a scoreboard that a
// negedge monitor pops whenever done fires. A CNT_W=3 instance checks saturation.
module tb_seq_detect_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic det_y = 1'b0;
    logic det_clr, det_x, s_det_clr, s_det_x;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ptr_m = 0;
    bit sat_done_seen = 1'b0;

    typedef struct { int ch; int cnt; } exp_t;
    exp_t sb[$];

    seq_detect_arbiter_if #(.NCH(4), .CNT_W(5)) bus ();
    seq_detect_arbiter_if #(.NCH(4), .CNT_W(3)) sbus ();

    assign sbus.bit_in = bus.bit_in;

    seq_detect_arbiter #(.NCH(4), .FRAME_LEN(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus), .det_clr(det_clr), .det_x(det_x), .det_y(det_y)
    );

    seq_detect_arbiter #(.NCH(4), .FRAME_LEN(16), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus), .det_clr(s_det_clr), .det_x(s_det_x), .det_y(det_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: every done pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbus.done) sat_done_seen = 1'b1;
            if (bus.done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done ch=%0d cnt=%0d at cyc %0d", bus.done_ch, bus.match_cnt, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.done_ch !== 3'(e.ch) || bus.match_cnt !== 5'(e.cnt)) begin
                        miscompares++;
                        $display("FAIL result ch=%0d cnt=%0d expected ch=%0d cnt=%0d", bus.done_ch, bus.match_cnt, e.ch, e.cnt);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(logic [3:0] r);
        int c;
`ifdef SEQ_ARB_FIXED_PRI_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int off = 0; off < 4; off++) begin
            c = (ptr_m + off) % 4;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    // One frame from IDLE back to IDLE; optional mid-frame req edits and abort by reset.
    task automatic run_frame(input logic [3:0] rq, input logic [15:0] ymask,
                             input int drop_at, input int add_at, input logic [3:0] add_val,
                             input int rst_at, input bit sat, output int ch);
        int n;
        logic [3:0] oh;
        ch = pick(rq);
`ifndef SEQ_ARB_FIXED_PRI_EN
        ptr_m = (ch + 1) % 4;
`endif
        oh = 4'b0001 << ch;
        n = $countones(ymask);
        if (n > 31) n = 31;
        if (rst_at < 0) sb.push_back('{ch, n});
        bus.req = rq;
        if (sat) sbus.req = rq;
        tick();
        if (sat) sbus.req = 4'b0;
        det_y = 1'($urandom);
        vectors++;
        if ({bus.gnt, bus.busy, det_clr, det_x} !== {oh, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL clr gnt=%b busy=%b clr=%b x=%b expected gnt=%b", bus.gnt, bus.busy, det_clr, det_x, oh);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == rst_at) begin
                rst = 1'b1;
                bus.req = 4'b0;
                tick();
                vectors++;
                if ({bus.gnt, bus.busy, bus.done, bus.match_cnt, det_clr, det_x} !== {4'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
                    miscompares++;
                    $display("FAIL midrst gnt=%b busy=%b done=%b cnt=%0d clr=%b x=%b", bus.gnt, bus.busy, bus.done, bus.match_cnt, det_clr, det_x);
                end
                tick();
                rst = 1'b0;
                ptr_m = 0;
                return;
            end
            if (i == drop_at) bus.req = bus.req & ~oh;
            if (i == add_at) bus.req = bus.req | add_val;
            bus.bit_in = 4'($urandom);
            det_y = (i == 0) ? 1'($urandom) : ymask[i-1];
            #1;
            vectors++;
            if ({bus.gnt, bus.busy, det_x, det_clr, bus.done} !== {oh, 1'b1, bus.bit_in[ch], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stream i=%0d gnt=%b busy=%b x=%b clr=%b done=%b expected gnt=%b x=%b", i, bus.gnt, bus.busy, det_x, det_clr, bus.done, oh, bus.bit_in[ch]);
            end
        end
        tick();
        det_y = ymask[15];
        bus.bit_in = 4'($urandom);
        #1;
        vectors++;
        if ({bus.gnt, det_x, det_clr, bus.done} !== {oh, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL drain gnt=%b x=%b clr=%b done=%b expected gnt=%b", bus.gnt, det_x, det_clr, bus.done, oh);
        end
        tick();
        det_y = 1'($urandom);
        vectors++;
        if ({bus.done, bus.gnt, bus.busy} !== {1'b1, 4'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL done_slot done=%b gnt=%b busy=%b expected 1/0000/1", bus.done, bus.gnt, bus.busy);
        end
        tick();
        vectors++;
        if ({bus.done, bus.gnt, bus.busy} !== {1'b0, 4'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL idle done=%b gnt=%b busy=%b expected 0/0000/0", bus.done, bus.gnt, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b0;
        bus.bit_in = 4'b0;
        sbus.req = 4'b0;
        det_y = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.gnt, bus.busy, bus.done, bus.match_cnt, det_clr, det_x} !== {4'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL reset gnt=%b busy=%b done=%b cnt=%0d clr=%b x=%b", bus.gnt, bus.busy, bus.done, bus.match_cnt, det_clr, det_x);
            end
        end
        rst = 1'b0;
        ptr_m = 0;
        tick();
        vectors++;
        if ({det_clr, bus.busy, bus.done_ch} !== {1'b0, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_release clr=%b busy=%b done_ch=%0d", det_clr, bus.busy, bus.done_ch);
        end
    endtask

    task automatic test_round_robin();
        int ch;
        for (int f = 0; f < 5; f++) run_frame(4'b1111, 16'($urandom), -1, -1, 4'b0, -1, 1'b0, ch);
    endtask

    task automatic test_single();
        int ch;
        run_frame(4'b0100, 16'h8891, -1, -1, 4'b0, -1, 1'b0, ch);
    endtask

    task automatic test_mid_frame();
        int ch;
        run_frame(4'b0010, 16'($urandom), 4, 6, 4'b1000, -1, 1'b0, ch);
        run_frame(4'b1000, 16'($urandom), -1, -1, 4'b0, -1, 1'b0, ch);
    endtask

    task automatic test_reset_mid();
        int ch;
        run_frame(4'b0100, 16'hFFFF, -1, -1, 4'b0, 7, 1'b0, ch);
        run_frame(4'b0011, 16'h0F0F, -1, -1, 4'b0, -1, 1'b0, ch);
    endtask

    task automatic test_saturation();
        int ch;
        sat_done_seen = 1'b0;
        run_frame(4'b0001, 16'hFFFF, -1, -1, 4'b0, -1, 1'b1, ch);
        vectors++;
        if ({sat_done_seen, sbus.match_cnt, sbus.done_ch} !== {1'b1, 3'd7, 3'd0}) begin
            miscompares++;
            $display("FAIL saturation seen=%b cnt=%0d ch=%0d expected 1/7/0", sat_done_seen, sbus.match_cnt, sbus.done_ch);
        end
    endtask

    task automatic test_fixed_pri();
        int ch;
        for (int f = 0; f < 3; f++) run_frame(4'b0011, 16'($urandom), -1, -1, 4'b0, -1, 1'b0, ch);
    endtask

    task automatic test_back_to_back();
        int ch;
        for (int f = 0; f < 4; f++)
            run_frame(4'($urandom_range(1, 15)), 16'($urandom), -1, -1, 4'b0, -1, 1'b0, ch);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_mid_frame();
        test_reset_mid();
        test_saturation();
        test_fixed_pri();
        test_back_to_back();
        bus.req = 4'b0;
        repeat (3) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_done pending=%0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
